// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared defaults and FSM encoding for the SPI shift engine
package spi_pkg;

  localparam int SPI_DATA_W = 32;
  localparam int SPI_LEN_W  = 5;
  localparam int SPI_DIV_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_clk_tick.sv
// rtl/spi_clk_tick.sv - divider down-counter producing one tick every div+1 cycles
module spi_clk_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  // The divider is captured on load so later changes to div cannot stretch a running transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (load) begin
      cnt   <= div;
      div_q <= div;
    end else if (en) begin
      if (cnt == '0) begin
        cnt <= div_q;
      end else begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end

  assign tick = en && !load && (cnt == '0);

endmodule

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - full-duplex SPI master shift engine with configurable mode, length and divider
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int LEN_W  = SPI_LEN_W,
  parameter int DIV_W  = SPI_DIV_W
) (
  input  logic              FCLK_CLK0,
  input  logic              RST,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic [LEN_W-1:0]  i_num_bits,
  input  logic [DIV_W-1:0]  i_clk_div,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_cs_n,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso
);

  spi_state_t state, state_nxt;

  logic              accept;
  logic              tick;
  logic              tick_en;
  logic              leading;
  logic              last_edge;
  logic              sample_en;
  logic              drive_en;
  logic              cpha_q;
  logic              lsb_q;
  logic [LEN_W-1:0]  nm1_in;
  logic [LEN_W-1:0]  nm1_q;
  logic [LEN_W:0]    edge_cnt;
  logic [DATA_W-1:0] tx_load;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;

  function automatic logic head_bit(input logic [DATA_W-1:0] sr, input logic lsb);
    return lsb ? sr[0] : sr[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] sr, input logic lsb);
    return lsb ? (sr >> 1) : (sr << 1);
  endfunction

  assign accept  = i_start && !o_busy && (state == ST_IDLE);
  assign tick_en = (state != ST_IDLE);

  // N-1 wraps 0 to all-ones, so a zero length naturally selects DATA_W bits;
  // ~(N-1) equals DATA_W-N because DATA_W is 2**LEN_W.
  assign nm1_in  = i_num_bits - LEN_W'(1);
  assign tx_load = i_lsb_first ? i_tx_data : (i_tx_data << ~nm1_in);

  assign leading   = ~edge_cnt[0];
  assign last_edge = (edge_cnt == {nm1_q, 1'b1});
  assign sample_en = tick && (state == ST_XFER) && (leading ^ cpha_q);
  assign drive_en  = tick && (state == ST_XFER) &&
                     (cpha_q ? leading : (!leading && !last_edge));

  spi_clk_tick #(
    .DIV_W (DIV_W)
  ) u_clk_tick (
    .clk  (FCLK_CLK0),
    .rst  (RST),
    .load (accept),
    .en   (tick_en),
    .div  (i_clk_div),
    .tick (tick)
  );

  always_ff @(posedge FCLK_CLK0) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_LEAD;
      ST_LEAD:  if (tick) state_nxt = ST_XFER;
      ST_XFER:  if (tick && last_edge) state_nxt = ST_TRAIL;
      ST_TRAIL: if (tick) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge FCLK_CLK0) begin
    if (RST) begin
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rx_data <= '0;
      o_cs_n    <= 1'b1;
      o_sclk    <= 1'b0;
      o_mosi    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      nm1_q     <= '0;
      edge_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
    end else begin
      o_done <= 1'b0;
      // busy stays up through the done cycle so a start there is ignored
      if (o_done) begin
        o_busy <= 1'b0;
      end

      if (accept) begin
        o_busy   <= 1'b1;
        o_cs_n   <= 1'b0;
        o_sclk   <= i_cpol;
        cpha_q   <= i_cpha;
        lsb_q    <= i_lsb_first;
        nm1_q    <= nm1_in;
        edge_cnt <= '0;
        rx_sr    <= '0;
        if (!i_cpha) begin
          o_mosi <= head_bit(tx_load, i_lsb_first);
          tx_sr  <= advance(tx_load, i_lsb_first);
        end else begin
          tx_sr  <= tx_load;
        end
      end

      if (tick && (state == ST_XFER)) begin
        o_sclk   <= ~o_sclk;
        edge_cnt <= edge_cnt + (LEN_W + 1)'(1);
      end

      if (sample_en) begin
        rx_sr <= lsb_q ? {i_miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], i_miso};
      end

      if (drive_en) begin
        o_mosi <= head_bit(tx_sr, lsb_q);
        tx_sr  <= advance(tx_sr, lsb_q);
      end

      // LSB-first fills from the top, so right-align by DATA_W-N at completion
      if (tick && (state == ST_TRAIL)) begin
        o_cs_n    <= 1'b1;
        o_done    <= 1'b1;
        o_rx_data <= lsb_q ? (rx_sr >> ~nm1_q) : rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - directed self-checking bench for spi_shift_engine
module tb_spi_shift_engine;

  logic        FCLK_CLK0 = 1'b0;
  logic        RST = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_tx_data = '0;
  logic [4:0]  i_num_bits = '0;
  logic [7:0]  i_clk_div = '0;
  logic        i_cpol = 1'b0;
  logic        i_cpha = 1'b0;
  logic        i_lsb_first = 1'b0;
  logic        i_miso;
  logic        o_busy, o_done, o_cs_n, o_sclk, o_mosi;
  logic [31:0] o_rx_data;

  logic [1:0]  miso_mode = 2'd0;
  logic [2:0]  slv_cnt = 3'd0;
  logic        slv_prev = 1'b0;
  logic        slv_cs_prev = 1'b1;
  logic [7:0]  slv_word = 8'hC3;

  int total = 0;
  int bad = 0;

  spi_shift_engine dut (
    .FCLK_CLK0   (FCLK_CLK0),
    .RST         (RST),
    .i_start     (i_start),
    .i_tx_data   (i_tx_data),
    .i_num_bits  (i_num_bits),
    .i_clk_div   (i_clk_div),
    .i_cpol      (i_cpol),
    .i_cpha      (i_cpha),
    .i_lsb_first (i_lsb_first),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rx_data   (o_rx_data),
    .o_cs_n      (o_cs_n),
    .o_sclk      (o_sclk),
    .o_mosi      (o_mosi),
    .i_miso      (i_miso)
  );

  always #5 FCLK_CLK0 = ~FCLK_CLK0;

  always_comb begin
    i_miso = 1'b0;
    case (miso_mode)
      2'd0: i_miso = o_mosi;
      2'd1: i_miso = slv_word[3'd7 - slv_cnt];
      2'd2: i_miso = 1'b1;
      default: i_miso = 1'b0;
    endcase
  end

  // Slave presents MSB first and advances after each trailing edge (SCLK returning to CPOL).
  always @(posedge FCLK_CLK0) begin
    slv_prev    <= o_sclk;
    slv_cs_prev <= o_cs_n;
    if (o_cs_n) slv_cnt <= 3'd0;
    else if (!slv_cs_prev && (o_sclk !== slv_prev) && (o_sclk === i_cpol)) slv_cnt <= slv_cnt + 3'd1;
  end

  task automatic run_xfer(input logic [31:0] tx, input logic [4:0] nb, input logic [7:0] dv,
                          input logic cp, input logic ph, input logic lsb,
                          output int cyc, output int tog, output int bsy,
                          output logic lead_mosi, output logic lead_csn, output logic idle_sclk,
                          output logic [31:0] rx);
    logic prev;
    i_tx_data = tx; i_num_bits = nb; i_clk_div = dv;
    i_cpol = cp; i_cpha = ph; i_lsb_first = lsb;
    i_start = 1'b1;
    @(negedge FCLK_CLK0);
    i_start = 1'b0;
    cyc = 1; tog = 0; bsy = 0;
    lead_mosi = o_mosi; lead_csn = o_cs_n; prev = o_sclk;
    while (1) begin
      if (o_busy === 1'b1) bsy++;
      if (o_sclk !== prev) tog++;
      prev = o_sclk;
      if (o_done === 1'b1 || cyc >= 4000) break;
      @(negedge FCLK_CLK0);
      cyc++;
    end
    rx = o_rx_data;
    @(negedge FCLK_CLK0);
    idle_sclk = o_sclk;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge FCLK_CLK0);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_done); end
    total++; if (o_rx_data !== 32'h0) begin bad++; $display("FAIL reset_rx got=%h want=0", o_rx_data); end
    total++; if (o_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", o_cs_n); end
    total++; if (o_sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", o_sclk); end
    total++; if (o_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", o_mosi); end
    RST = 1'b0;
    @(negedge FCLK_CLK0);
  endtask

  task automatic test_mode0_loopback;
    int cyc, tog, bsy; logic lm, lc, isc; logic [31:0] rx;
    miso_mode = 2'd0;
    run_xfer(32'hA5, 5'd8, 8'd0, 1'b0, 1'b0, 1'b0, cyc, tog, bsy, lm, lc, isc, rx);
    total++; if (cyc !== 19) begin bad++; $display("FAIL t1_latency got=%0d want=19", cyc); end
    total++; if (tog !== 16) begin bad++; $display("FAIL t1_edges got=%0d want=16", tog); end
    total++; if (rx !== 32'hA5) begin bad++; $display("FAIL t1_rx got=%h want=000000a5", rx); end
    total++; if (lm !== 1'b1) begin bad++; $display("FAIL t1_lead_mosi got=%b want=1", lm); end
    total++; if (lc !== 1'b0) begin bad++; $display("FAIL t1_lead_cs_n got=%b want=0", lc); end
    total++; if (isc !== 1'b0) begin bad++; $display("FAIL t1_idle_sclk got=%b want=0", isc); end
  endtask

  task automatic test_mode3_slave;
    int cyc, tog, bsy; logic lm, lc, isc; logic [31:0] rx;
    miso_mode = 2'd1;
    run_xfer(32'h3C, 5'd8, 8'd3, 1'b1, 1'b1, 1'b0, cyc, tog, bsy, lm, lc, isc, rx);
    total++; if (cyc !== 73) begin bad++; $display("FAIL t2_latency got=%0d want=73", cyc); end
    total++; if (tog !== 16) begin bad++; $display("FAIL t2_edges got=%0d want=16", tog); end
    total++; if (rx !== 32'hC3) begin bad++; $display("FAIL t2_rx got=%h want=000000c3", rx); end
    total++; if (isc !== 1'b1) begin bad++; $display("FAIL t2_idle_sclk got=%b want=1", isc); end
    miso_mode = 2'd0;
  endtask

  task automatic test_lsb_32bit;
    int cyc, tog, bsy; logic lm, lc, isc; logic [31:0] rx;
    miso_mode = 2'd0;
    run_xfer(32'h12345678, 5'd0, 8'd1, 1'b0, 1'b0, 1'b1, cyc, tog, bsy, lm, lc, isc, rx);
    total++; if (lm !== 1'b0) begin bad++; $display("FAIL t3_first_mosi got=%b want=0", lm); end
    total++; if (rx !== 32'h12345678) begin bad++; $display("FAIL t3_rx got=%h want=12345678", rx); end
    total++; if (bsy !== 133) begin bad++; $display("FAIL t3_busy_cycles got=%0d want=133", bsy); end
    total++; if (cyc !== 133) begin bad++; $display("FAIL t3_latency got=%0d want=133", cyc); end
    total++; if (tog !== 64) begin bad++; $display("FAIL t3_edges got=%0d want=64", tog); end
  endtask

  task automatic test_short_len;
    int cyc, tog, bsy; logic lm, lc, isc; logic [31:0] rx;
    miso_mode = 2'd2;
    run_xfer(32'hFFFFFFFF, 5'd5, 8'd0, 1'b0, 1'b0, 1'b0, cyc, tog, bsy, lm, lc, isc, rx);
    total++; if (tog !== 10) begin bad++; $display("FAIL t4_edges got=%0d want=10", tog); end
    total++; if (rx !== 32'h1F) begin bad++; $display("FAIL t4_rx got=%h want=0000001f", rx); end
    total++; if (cyc !== 13) begin bad++; $display("FAIL t4_latency got=%0d want=13", cyc); end
    miso_mode = 2'd0;
  endtask

  task automatic test_back_to_back;
    int ndone, d1, d2; logic [31:0] rx1, rx2; logic b12, b13;
    miso_mode = 2'd0;
    ndone = 0; d1 = 0; d2 = 0; rx1 = '0; rx2 = '0; b12 = 1'bx; b13 = 1'bx;
    i_tx_data = 32'h9; i_num_bits = 5'd4; i_clk_div = 8'd0;
    i_cpol = 1'b0; i_cpha = 1'b0; i_lsb_first = 1'b0;
    i_start = 1'b1;
    @(negedge FCLK_CLK0);
    for (int c = 1; c <= 40; c++) begin
      if (o_done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin d1 = c; rx1 = o_rx_data; end
        else if (ndone == 2) begin d2 = c; rx2 = o_rx_data; end
      end
      if (c == 12) b12 = o_busy;
      if (c == 13) b13 = o_busy;
      if (c == 5) i_tx_data = 32'h6;
      if (c == 23) i_start = 1'b0;
      @(negedge FCLK_CLK0);
    end
    total++; if (ndone !== 2) begin bad++; $display("FAIL t5_done_count got=%0d want=2", ndone); end
    total++; if (d1 !== 11) begin bad++; $display("FAIL t5_done1_cycle got=%0d want=11", d1); end
    total++; if (d2 !== 23) begin bad++; $display("FAIL t5_done2_cycle got=%0d want=23", d2); end
    total++; if (b12 !== 1'b0) begin bad++; $display("FAIL t5_busy_after_done got=%b want=0", b12); end
    total++; if (b13 !== 1'b1) begin bad++; $display("FAIL t5_busy_restart got=%b want=1", b13); end
    total++; if (rx1 !== 32'h9) begin bad++; $display("FAIL t5_rx1 got=%h want=00000009", rx1); end
    total++; if (rx2 !== 32'h6) begin bad++; $display("FAIL t5_rx2 got=%h want=00000006", rx2); end
  endtask

  task automatic test_rst_mid;
    int tog, c; logic prev, seen_done;
    miso_mode = 2'd0;
    i_tx_data = 32'h5A; i_num_bits = 5'd8; i_clk_div = 8'd1;
    i_cpol = 1'b0; i_cpha = 1'b0; i_lsb_first = 1'b0;
    i_start = 1'b1;
    @(negedge FCLK_CLK0);
    i_start = 1'b0;
    prev = o_sclk; tog = 0; c = 0; seen_done = 1'b0;
    while (tog < 5 && c < 500) begin
      @(negedge FCLK_CLK0);
      c++;
      if (o_sclk !== prev) tog++;
      prev = o_sclk;
      if (o_done === 1'b1) seen_done = 1'b1;
    end
    total++; if (tog !== 5) begin bad++; $display("FAIL t6_edge_wait got=%0d want=5", tog); end
    RST = 1'b1;
    @(negedge FCLK_CLK0);
    RST = 1'b0;
    total++; if (o_cs_n !== 1'b1) begin bad++; $display("FAIL t6_cs_n got=%b want=1", o_cs_n); end
    total++; if (o_sclk !== 1'b0) begin bad++; $display("FAIL t6_sclk got=%b want=0", o_sclk); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t6_busy got=%b want=0", o_busy); end
    total++; if (o_rx_data !== 32'h0) begin bad++; $display("FAIL t6_rx got=%h want=0", o_rx_data); end
    repeat (12) begin
      if (o_done === 1'b1) seen_done = 1'b1;
      @(negedge FCLK_CLK0);
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL t6_no_done got=%b want=0", seen_done); end
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_mode3_slave();
    test_lsb_32bit();
    test_short_len();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
